sha256_compress_2x: RTL and testbench

Two-rounds-per-cycle SHA-256 compression core sitting directly downstream of the message scheduler. It consumes the scheduler's stream of 32 word pairs (W[2i], W[2i+1]) and runs rounds 2i and 2i+1 in one cycle. It adds the working variables back into the chaining value and presents a 256-bit digest. Multi-block messages chain through an internal hash register.

---
 rtl/sha256_compress_2x_if.sv | 21 ++
 rtl/sha256_compress_2x.sv | 100 ++++++++++
 tb/tb_sha256_compress_2x.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_compress_2x_if.sv
// Scheduler-to-compression-core link: word-pair stream in, digest and status out.
interface sha256_compress_2x_if;
    logic         block_start;
    logic         first_block;
    logic         w_valid;
    logic [31:0]  w0_in;
    logic [31:0]  w1_in;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;

    modport master (
        output block_start, first_block, w_valid, w0_in, w1_in,
        input  busy, digest, digest_valid
    );

    modport slave (
        input  block_start, first_block, w_valid, w0_in, w1_in,
        output busy, digest, digest_valid
    );
endinterface

// File: rtl/sha256_compress_2x.sv
// SHA-256 compression core running two rounds per cycle on scheduler word pairs,
// with an internal chaining register for multi-block messages.
module sha256_compress_2x (
    input  logic                   clk,
    input  logic                   reset,
    sha256_compress_2x_if.slave    io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL} state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Working variables packed a..h from MSB down, same lane order as the digest.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t       r_state;
    logic [4:0]   r_cnt;
    logic [255:0] r_wv;
    logic [255:0] r_h;
    logic [255:0] r_digest;
    logic         r_digest_valid;

    logic [255:0] w_round0;
    logic [255:0] w_round1;
    logic [255:0] w_h_next;

    always_comb begin
        w_round0 = sha_round(r_wv, K[{r_cnt, 1'b0}], io_bus.w0_in);
        w_round1 = sha_round(w_round0, K[{r_cnt, 1'b1}], io_bus.w1_in);
        w_h_next = '0;
        for (int j = 0; j < 8; j++)
            w_h_next[j*32 +: 32] = r_h[j*32 +: 32] + r_wv[j*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_wv           <= '0;
            r_h            <= '0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Chaining from H right after reset is legal and uses H=0.
                    if (io_bus.block_start) begin
                        if (io_bus.first_block)
                            r_h <= IV;
                        r_wv    <= io_bus.first_block ? IV : r_h;
                        r_cnt   <= '0;
                        r_state <= S_ROUNDS;
                    end
                end
                S_ROUNDS: begin
                    if (io_bus.w_valid) begin
                        r_wv  <= w_round1;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31)
                            r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_h            <= w_h_next;
                    r_digest       <= w_h_next;
                    r_digest_valid <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.busy         = (r_state != S_IDLE);
    assign io_bus.digest       = r_digest;
    assign io_bus.digest_valid = r_digest_valid;
endmodule

// File: tb/tb_sha256_compress_2x.sv
// Randomized scoreboard bench for sha256_compress_2x against a plain 64-round SHA-256 model.
module tb_sha256_compress_2x;
    logic clk;
    logic reset;
    sha256_compress_2x_if bus();

    sha256_compress_2x dut (.clk(clk), .reset(reset), .io_bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] dig;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] TWO_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};

    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic [31:0]  wsched [64];
    logic [255:0] model_h = '0;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic fill_sched(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) wsched[t] = blk[511 - 32*t -: 32];
            else wsched[t] = (rr(wsched[t-2], 17) ^ rr(wsched[t-2], 19) ^ (wsched[t-2] >> 10))
                           + wsched[t-7]
                           + (rr(wsched[t-15], 7) ^ rr(wsched[t-15], 18) ^ (wsched[t-15] >> 3))
                           + wsched[t-16];
        end
    endtask

    // Textbook compression over the schedule in wsched, variables held in an array.
    function automatic logic [255:0] compress(input logic [255:0] hin);
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] hout;
        for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + KT[t] + wsched[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) hout[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
        return hout;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.digest_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_digest_valid: got digest_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digest", bus.digest, e.dig);
                chk("latency_cycle", 256'(cyc), 256'(e.cyc));
                chk("busy_at_done", 256'(bus.busy), 256'(0));
            end
        end
    end

    // One block: optional stalls, spurious block_start at offsets 5/20, reset abort at a given offset.
    task automatic send_block(input logic [511:0] blk, input bit first, input int nstall,
                              input bit spurious, input bit chain_now, input int abort_at,
                              input bit ovr_en, input logic [255:0] ovr);
        int stalls [32];
        int rel;
        logic [255:0] exp;
        exp_t e;
        for (int p = 0; p < 32; p++) stalls[p] = 0;
        for (int s = 0; s < nstall; s++) stalls[$urandom_range(31, 1)]++;
        fill_sched(blk);
        bus.block_start = 1'b1;
        bus.first_block = first;
        bus.w_valid     = 1'b0;
        if (abort_at == 0) begin
            exp = compress(first ? IV : model_h);
            model_h = exp;
            e.dig = ovr_en ? ovr : exp;
            e.cyc = cyc + 34 + nstall;
            sb.push_back(e);
        end
        tick();
        bus.block_start = 1'b0;
        rel = 1;
        chk("busy_cycle1", 256'(bus.busy), 256'(1));
        for (int p = 0; p < 32; p++) begin
            for (int s = 0; s <= stalls[p]; s++) begin
                if (abort_at != 0 && rel == abort_at) begin
                    reset = 1'b1;
                    bus.w_valid = 1'b0;
                    tick();
                    chk("abort_busy", 256'(bus.busy), 256'(0));
                    chk("abort_digest", bus.digest, 256'(0));
                    chk("abort_dvalid", 256'(bus.digest_valid), 256'(0));
                    reset = 1'b0;
                    model_h = '0;
                    return;
                end
                bus.block_start = spurious && (rel == 5 || rel == 20);
                bus.first_block = 1'b1;
                bus.w_valid = (s == stalls[p]);
                bus.w0_in = bus.w_valid ? wsched[2*p]   : $urandom;
                bus.w1_in = bus.w_valid ? wsched[2*p+1] : $urandom;
                tick();
                rel++;
            end
        end
        bus.block_start = 1'b0;
        bus.w_valid = 1'b0;
        chk("busy_final", 256'(bus.busy), 256'(1));
        tick();
        if (!chain_now) repeat ($urandom_range(3, 0)) tick();
    endtask

    initial begin
        logic [511:0] rblk;
        reset = 1'b1;
        bus.block_start = 1'b0;
        bus.first_block = 1'b0;
        bus.w_valid = 1'b0;
        bus.w0_in = '0;
        bus.w1_in = '0;
        repeat (3) tick();
        chk("reset_busy", 256'(bus.busy), 256'(0));
        chk("reset_digest", bus.digest, 256'(0));
        chk("reset_dvalid", 256'(bus.digest_valid), 256'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            bus.w_valid = 1'b1;
            bus.w0_in = $urandom;
            bus.w1_in = $urandom;
            tick();
            chk("idle_wvalid_busy", 256'(bus.busy), 256'(0));
        end
        bus.w_valid = 1'b0;

        for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
        send_block(rblk, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, '0);

        send_block(ABC_BLK, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1, ABC_DIG);
        send_block(TWO_B1, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0, '0);
        send_block(TWO_B2, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, TWO_DIG);
        send_block(ABC_BLK, 1'b1, 3, 1'b0, 1'b0, 0, 1'b1, ABC_DIG);
        send_block(ABC_BLK, 1'b1, 0, 1'b1, 1'b0, 0, 1'b1, ABC_DIG);
        send_block(ABC_BLK, 1'b1, 0, 1'b0, 1'b0, 15, 1'b0, '0);
        send_block(ABC_BLK, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1, ABC_DIG);

        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
            send_block(rblk, (b == 0) ? 1'b1 : 1'($urandom_range(1, 0)), $urandom_range(4, 0),
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, 1'b0, '0);
        end

        for (int w = 0; w < 100 && (sb.size() != 0 || bus.busy); w++) tick();
        tick();
        if (sb.size() != 0 || bus.busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending digests expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
